commit_trace_fifo: RTL and testbench
====================================

// Module: commit_trace_fifo
// PURPOSE
//  Commit-trace buffer downstream of the mips core's M/W observation ports.
//  - Captures every data-memory store and every non-$0 GRF writeback.
//  - Tags each event with a cycle stamp and queues it in a FIFO.
//  - Drains one record per cycle over a valid/ready port to a log sink (bench
//    printer, UART, or golden-trace comparator).
//  - Replaces ad-hoc $display tracing with a synthesizable, back-pressured stream.
// PARAMETERS
//  DEPTH  16  FIFO entries; power of two, >= 4
//  CNT_W  32  width of the free-running cycle counter / record stamp
// PORTS
//  clk            in   1      system clock, all state updates on posedge
//  reset          in   1      synchronous, active-high
//  m_inst_addr    in   32     PC of instruction in M stage
//  m_data_addr    in   32     data-memory byte address from core
//  m_data_wdata   in   32     store data from core (byte lanes already placed)
//  m_data_byteen  in   4      store byte enables; 0 = no store this cycle
//  m_data_rdata   in   32     current memory word at m_data_addr (for merge)
//  w_grf_we       in   1      GRF write enable, W stage
//  w_grf_addr     in   5      GRF destination register
//  w_grf_wdata    in   32     GRF write data
//  w_inst_addr    in   32     PC of instruction in W stage
//  trc_valid      out  1      head record available
//  trc_ready      in   1      sink accepts head record this cycle
//  trc_kind       out  1      0 = GRF write, 1 = memory store
//  trc_cycle      out  CNT_W  cycle stamp of the event
//  trc_pc         out  32     PC of committing instruction
//  trc_addr       out  32     GRF: {27'b0,reg}; MEM: word address (addr & ~3)
//  trc_data       out  32     GRF: wdata; MEM: merged word after the store
//  overflow       out  1      sticky: at least one event dropped
//  level          out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset: FIFO flushed, cycle=0, trc_valid=0, overflow=0, level=0.
//    All record outputs read 0 while empty. Events presented while reset=1
//    are ignored. A reset mid-drain discards all queued records.
//  - Cycle counter: +1 every non-reset posedge; wraps modulo 2^CNT_W.
//    Stamp = counter value before the increment at the capturing edge.
//  - MEM event: |m_data_byteen. Merged word = m_data_rdata with byte lane i
//    replaced by m_data_wdata lane i where byteen[i]=1.
//  - GRF event: w_grf_we && w_grf_addr != 0. Writes to $0 never recorded.
//  - Both events in one cycle: two entries pushed, MEM first, then GRF. Same
//    stamp on both (MEM is the younger instruction, but the core's print order
//    within a cycle is store-first).
//  - Push and pop rules:
//    - Up to 2 pushes and 1 pop per edge.
//    - Pop = trc_valid && trc_ready.
//    - Free space for this edge = DEPTH - level + pop (same-edge pop frees a
//      slot).
//  - Overflow: events are pushed in order until space runs out; remaining
//    events are dropped, overflow set, and it stays set until reset.
//    Never a partial or corrupted record.
//  - Output: show-ahead. trc_valid = (level != 0). Record fields come straight
//    from the head entry and stay stable while trc_valid && !trc_ready.
//  - Latency: event sampled at edge N -> trc_valid high after edge N if the
//    FIFO was empty.
//  - Pointers: wrap modulo DEPTH. Full is level == DEPTH; level never exceeds
//    DEPTH.
// TESTING
//  1. Reset held 3 cycles with byteen=4'hF, we=1 -> no records, level=0,
//     overflow=0, cycle=0 after release.
//  2. Store byteen=4'b0011, addr=0x13, rdata=0xAABBCCDD, wdata=0x11223344,
//     pc=0x3004 -> one record: kind=1, addr=0x10, data=0xAABB3344,
//     pc=0x3004, trc_valid next cycle.
//  3. GRF we=1, reg=0 -> no record. Same cycle with reg=5, wdata=0xDEADBEEF,
//     pc=0x3008 -> kind=0, addr=5, data=0xDEADBEEF.
//  4. Store and GRF write in the same cycle (ready=1) -> MEM record first,
//     then GRF on the next cycle, identical trc_cycle stamps.
//  5. trc_ready=0, 2 events/cycle until full (DEPTH=16) -> level=16, then the
//     next events are dropped and overflow=1. Head record is unchanged
//     throughout the stall.
//  6. level=15, ready=1 with 2 events -> pop frees a slot, both pushed,
//     level=16, overflow stays 0. Assert reset mid-drain -> level=0 next
//     cycle.

Source files
------------

// File: rtl/commit_trace_fifo.sv
// Commit-trace buffer: stamps M-stage stores and W-stage GRF writebacks and
// queues them as records drained over a back-pressured valid/ready port.
module commit_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              m_inst_addr,
    input  logic [31:0]              m_data_addr,
    input  logic [31:0]              m_data_wdata,
    input  logic [3:0]               m_data_byteen,
    input  logic [31:0]              m_data_rdata,
    input  logic                     w_grf_we,
    input  logic [4:0]               w_grf_addr,
    input  logic [31:0]              w_grf_wdata,
    input  logic [31:0]              w_inst_addr,
    output logic                     trc_valid,
    input  logic                     trc_ready,
    output logic                     trc_kind,
    output logic [CNT_W-1:0]         trc_cycle,
    output logic [31:0]              trc_pc,
    output logic [31:0]              trc_addr,
    output logic [31:0]              trc_data,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned RW = 1 + CNT_W + 96;

    logic [RW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [CNT_W-1:0] r_cycle;
    logic             r_overflow;

    logic             w_mem_evt;
    logic             w_grf_evt;
    logic             w_pop;
    logic [LW-1:0]    w_free;
    logic             w_push0;
    logic             w_push1;
    logic             w_drop;
    logic [31:0]      w_merged;
    logic [31:0]      w_word_addr;
    logic [RW-1:0]    w_mem_rec;
    logic [RW-1:0]    w_grf_rec;
    logic [RW-1:0]    w_rec0;
    logic [AW-1:0]    w_wr_ptr1;

    assign w_mem_evt = |m_data_byteen;
    assign w_grf_evt = w_grf_we && (w_grf_addr != 5'd0);

    always_comb begin
        w_merged = m_data_rdata;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) begin
                w_merged[8*i +: 8] = m_data_wdata[8*i +: 8];
            end
        end
    end

    assign w_word_addr = m_data_addr & 32'hFFFF_FFFC;
    assign w_mem_rec   = {1'b1, r_cycle, m_inst_addr, w_word_addr, w_merged};
    assign w_grf_rec   = {1'b0, r_cycle, w_inst_addr, {27'd0, w_grf_addr}, w_grf_wdata};
    // Store is queued ahead of a same-cycle writeback; the second slot is only
    // ever the GRF record.
    assign w_rec0      = w_mem_evt ? w_mem_rec : w_grf_rec;
    assign w_wr_ptr1   = r_wr_ptr + AW'(1);

    assign trc_valid = (r_level != '0);
    assign w_pop     = trc_valid && trc_ready;
    assign w_free    = LW'(DEPTH) - r_level + LW'(w_pop);
    assign w_push0   = (w_mem_evt || w_grf_evt) && (w_free != '0);
    assign w_push1   = w_mem_evt && w_grf_evt && (w_free >= LW'(2));
    assign w_drop    = ((w_mem_evt || w_grf_evt) && !w_push0) ||
                       (w_mem_evt && w_grf_evt && !w_push1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_cycle    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_cycle  <= r_cycle + CNT_W'(1);
            r_wr_ptr <= r_wr_ptr + AW'(w_push0) + AW'(w_push1);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_level  <= r_level + LW'(w_push0) + LW'(w_push1) - LW'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_push0) begin
                r_mem[r_wr_ptr] <= w_rec0;
            end
            if (w_push1) begin
                r_mem[w_wr_ptr1] <= w_grf_rec;
            end
        end
    end

    // Record fields read as zero while the queue is empty.
    always_comb begin
        {trc_kind, trc_cycle, trc_pc, trc_addr, trc_data} = '0;
        if (trc_valid) begin
            {trc_kind, trc_cycle, trc_pc, trc_addr, trc_data} = r_mem[r_rd_ptr];
        end
    end

    assign overflow = r_overflow;
    assign level    = r_level;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: directed scenarios plus random traffic, with a
// queue-based reference model and a negedge monitor that scores the stream.
module tb_commit_trace_fifo;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic        kind;
        logic [31:0] cyc;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m_inst_addr = '0;
    logic [31:0] m_data_addr = '0;
    logic [31:0] m_data_wdata = '0;
    logic [3:0]  m_data_byteen = '0;
    logic [31:0] m_data_rdata = '0;
    logic        w_grf_we = 1'b0;
    logic [4:0]  w_grf_addr = '0;
    logic [31:0] w_grf_wdata = '0;
    logic [31:0] w_inst_addr = '0;
    logic        trc_valid;
    logic        trc_ready = 1'b0;
    logic        trc_kind;
    logic [31:0] trc_cycle;
    logic [31:0] trc_pc;
    logic [31:0] trc_addr;
    logic [31:0] trc_data;
    logic        overflow;
    logic [4:0]  level;

    commit_trace_fifo #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .m_inst_addr(m_inst_addr), .m_data_addr(m_data_addr),
        .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
        .m_data_rdata(m_data_rdata), .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
        .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_kind(trc_kind),
        .trc_cycle(trc_cycle), .trc_pc(trc_pc), .trc_addr(trc_addr),
        .trc_data(trc_data), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    rec_t exp_q[$];
    logic exp_ovf = 1'b0;
    logic [31:0] model_cyc = '0;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, want);
        end
    endtask

    function automatic rec_t dut_rec();
        return '{kind: trc_kind, cyc: trc_cycle, pc: trc_pc, addr: trc_addr, data: trc_data};
    endfunction

    function automatic rec_t model_mem_rec(input logic [31:0] stamp);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) if (m_data_byteen[i]) mask |= 32'hFF << (8 * i);
        return '{kind: 1'b1, cyc: stamp, pc: m_inst_addr, addr: m_data_addr & ~32'd3,
                 data: (m_data_rdata & ~mask) | (m_data_wdata & mask)};
    endfunction

    function automatic void model_push(input rec_t r);
        if (exp_q.size() < DEPTH) exp_q.push_back(r);
        else exp_ovf = 1'b1;
    endfunction

    // Monitor: sink pops happen on the edge after this sample.
    always @(negedge clk) begin
        if (!reset) begin
            check("level", 160'(level), 160'(exp_q.size()));
            check("valid", 160'(trc_valid), 160'(exp_q.size() != 0));
            check("overflow", 160'(overflow), 160'(exp_ovf));
            if (exp_q.size() == 0) begin
                check("empty_fields", 160'(dut_rec()), 160'(0));
            end else begin
                check("record", 160'(dut_rec()), 160'(exp_q[0]));
                if (trc_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic [3:0] be, input logic we, input logic [4:0] ra,
                        input logic rdy, input logic rst);
        m_data_byteen = be;
        w_grf_we      = we;
        w_grf_addr    = ra;
        trc_ready     = rdy;
        reset         = rst;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_ovf   = 1'b0;
            model_cyc = '0;
        end else begin
            if (be != 4'd0) model_push(model_mem_rec(model_cyc));
            if (we && ra != 5'd0)
                model_push('{kind: 1'b0, cyc: model_cyc, pc: w_inst_addr,
                             addr: {27'd0, ra}, data: w_grf_wdata});
            model_cyc++;
        end
        #1;
    endtask

    task automatic rand_fields();
        m_inst_addr  = $urandom;
        m_data_addr  = $urandom;
        m_data_wdata = $urandom;
        m_data_rdata = $urandom;
        w_grf_wdata  = $urandom;
        w_inst_addr  = $urandom;
    endtask

    rec_t        saved;
    logic [31:0] stamp;

    initial begin
        // 1: events during reset are ignored
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 5'd3, 1'b0, 1'b1);
        check("rst_level", 160'(level), 160'(0));
        check("rst_valid", 160'(trc_valid), 160'(0));
        check("rst_overflow", 160'(overflow), 160'(0));

        // 2: partial store, first edge after reset carries stamp 0
        m_data_addr = 32'h13; m_data_rdata = 32'hAABBCCDD;
        m_data_wdata = 32'h11223344; m_inst_addr = 32'h3004;
        step(4'b0011, 1'b0, 5'd0, 1'b0, 1'b0);
        check("st_valid", 160'(trc_valid), 160'(1));
        check("st_kind", 160'(trc_kind), 160'(1));
        check("st_addr", 160'(trc_addr), 160'(32'h10));
        check("st_data", 160'(trc_data), 160'(32'hAABB3344));
        check("st_pc", 160'(trc_pc), 160'(32'h3004));
        check("st_cycle", 160'(trc_cycle), 160'(0));

        // 3: $0 write ignored, $5 write recorded
        w_grf_wdata = 32'hDEADBEEF; w_inst_addr = 32'h3008;
        step(4'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        check("r0_level", 160'(level), 160'(0));
        step(4'd0, 1'b1, 5'd5, 1'b1, 1'b0);
        check("grf_kind", 160'(trc_kind), 160'(0));
        check("grf_addr", 160'(trc_addr), 160'(5));
        check("grf_data", 160'(trc_data), 160'(32'hDEADBEEF));
        check("grf_pc", 160'(trc_pc), 160'(32'h3008));

        // 4: store + writeback in one cycle, store first, same stamp
        rand_fields();
        step(4'hF, 1'b1, 5'd9, 1'b1, 1'b0);
        check("dual_kind0", 160'(trc_kind), 160'(1));
        stamp = trc_cycle;
        step(4'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        check("dual_kind1", 160'(trc_kind), 160'(0));
        check("dual_stamp", 160'(trc_cycle), 160'(stamp));
        step(4'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        check("dual_drained", 160'(level), 160'(0));

        // 5: stall until full, then drop
        for (int i = 0; i < 9; i++) begin
            rand_fields();
            step(4'b1100, 1'b1, 5'(1 + i), 1'b0, 1'b0);
            if (i == 0) saved = dut_rec();
            if (i == 7) begin
                check("full_level", 160'(level), 160'(16));
                check("full_noovf", 160'(overflow), 160'(0));
            end
        end
        check("ovf_level", 160'(level), 160'(16));
        check("ovf_set", 160'(overflow), 160'(1));
        check("ovf_head", 160'(dut_rec()), 160'(saved));
        step(4'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        check("ovf_cleared", 160'(overflow), 160'(0));

        // 6: same-edge pop frees the last slot; reset mid-drain
        for (int i = 0; i < 8; i++) begin
            rand_fields();
            step(4'h1, i < 7, 5'd7, 1'b0, 1'b0);
        end
        check("l15_level", 160'(level), 160'(15));
        rand_fields();
        step(4'h8, 1'b1, 5'd8, 1'b1, 1'b0);
        check("l15_push2_level", 160'(level), 160'(16));
        check("l15_push2_ovf", 160'(overflow), 160'(0));
        step(4'hF, 1'b1, 5'd8, 1'b1, 1'b1);
        check("mid_rst_level", 160'(level), 160'(0));
        check("mid_rst_valid", 160'(trc_valid), 160'(0));

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            rand_fields();
            step(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0,
                 1'($urandom), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0);
        end

        // Bounded drain
        for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++)
            step(4'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        step(4'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        check("final_level", 160'(level), 160'(0));
        check("final_model_empty", 160'(exp_q.size()), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
